rx_mf_decim: RTL and testbench
==============================

RX_MF_DECIM -- requirements
Module: rx_mf_decim

Interface
REQ-001 Parameter DECIM, default 4, decimation factor in input samples per symbol (legal range 2..8).
REQ-002 Parameter PHASE, default 0, the phase-counter value that triggers a symbol computation (legal range 0..DECIM-1).
REQ-003 Parameter THRESH, default 43691, outer slicer threshold in 1s17 format.
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 sam_en  input  1  input-sample strobe; x_in is accepted on each edge where sam_en=1.
REQ-007 x_in  input  18  signed 1s17 received sample at the TX pulse-shaping rate.
REQ-008 y  output  18  signed 1s17 matched-filter output at the symbol instant, registered.
REQ-009 y_valid  output  1  single-cycle strobe qualifying y and sym.
REQ-010 sym  output  2  Gray-coded 4-ASK decision, registered.
REQ-011 overrun  output  1  sticky flag: a trigger arrived while a computation was in progress.

Function
REQ-012 Delay line: 21 x 18-bit registers x[0..20]; on sam_en, x[0]<=x_in and x[k]<=x[k-1]; otherwise hold.
REQ-013 Phase counter: 0..DECIM-1; increments on sam_en, wraps DECIM-1->0; a trigger occurs on a sam_en edge where the pre-increment count equals PHASE.
REQ-014 Coefficients b[0..10], 1s17, fixed: 4095, 5901, 3327, -3449, -10679, -12461, -4028, 14916, 38992, 59145, 66992; symmetric 21-tap response, with b[k] applied to taps k and 20-k.
REQ-015 FSM states: IDLE, LOAD, MAC, OUT; reset state is IDLE.
REQ-016 IDLE->LOAD on a trigger (edge E0).
REQ-017 LOAD (E1): capture 19-bit pre-sums p[k]=x[k]+x[20-k] for k=0..9 and p[10]=x[10]; clear the accumulator; set k=0; go to MAC.
REQ-018 MAC (E2..E12): one shared 19x18 multiplier; acc+=p[k]*b[k], k=0..10, one product per clock; after k=10, go to OUT.
REQ-019 Accumulator is 41-bit signed, full precision, with no intermediate truncation.
REQ-020 Scaling: r=(acc+2^16)>>>17, arithmetic shift with round-half-up, then reduced to 18 bits per REQ-032/033.
REQ-021 OUT (E13): register y=r and sym; y_valid=1 for exactly one cycle; go to IDLE.
REQ-022 Latency: y_valid is high in the cycle following the 13th rising edge after the triggering sam_en edge.
REQ-023 Slicer: y>=THRESH -> 2'b10; 0<=y<THRESH -> 2'b11; -THRESH<=y<0 -> 2'b01; y<-THRESH -> 2'b00.
REQ-024 Delay line and phase counter keep advancing on sam_en in every FSM state; the computation uses only the LOAD snapshot.
REQ-025 A trigger in any state other than IDLE is dropped and sets overrun=1; the computation in progress completes normally.
REQ-026 A trigger on the same edge that OUT returns to IDLE is dropped and sets overrun.
REQ-027 y and sym hold between strobes.

Reset
REQ-028 Reset clears x[0..20], pre-sums, acc, k and the phase counter to 0, and puts the FSM in IDLE.
REQ-029 Reset values: y=0, y_valid=0, sym=2'b11, overrun=0.
REQ-030 Reset asserted mid-computation aborts it with no y_valid.
REQ-031 The first sam_en after reset release triggers when PHASE=0.

Configuration
REQ-032 Macro RX_MF_SAT_EN defined: r saturates to [-131072, 131071].
REQ-033 Macro RX_MF_SAT_EN undefined: r wraps, keeping its low 18 bits.

Verification
REQ-034 Reset, then no sam_en for 50 clocks -> y=0, sym=2'b11, y_valid=0, overrun=0 throughout.
REQ-035 Impulse test, PHASE=0: x_in=131071 on the first sam_en, 0 afterwards, sam_en every 16 clocks -> y sequence 4095, -10679, 38992, 38992, -10679, 4095, then 0; sym sequence 11, 01, 11, 11, 01, 11; each strobe occurs 13 clocks after its trigger.
REQ-036 PHASE=2, same impulse stimulus -> first y=3327, second y=-4028.
REQ-037 DC test: constant x_in=131071, sam_en every 16 clocks -> with RX_MF_SAT_EN, steady-state y=131071 and sym=2'b10; without it, y=-3636 and sym=2'b01.
REQ-038 Overrun test: sam_en every 2 clocks, DECIM=4 (trigger every 8 clocks) -> overrun=1 from the second trigger onward; a y_valid only every 16 clocks; overrun stays set until reset.
REQ-039 Mid-MAC reset: assert reset 5 clocks after a trigger -> no y_valid; all outputs at reset values; the next trigger after release computes from a zeroed delay line.

Source files
------------

// File: rtl/rx_mf_decim.sv
// rx_mf_decim: 21-tap symmetric matched filter, DECIM:1 decimation, Gray 4-ASK slicer; `RX_MF_SAT_EN saturates y instead of wrapping.
// Latency 13 clocks trigger->y_valid; no backpressure, a trigger while busy is dropped and sets sticky overrun.
module rx_mf_decim #(
   parameter int DECIM  = 4,
   parameter int PHASE  = 0,
   parameter int THRESH = 43691
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sam_en,
   input  logic [17:0] x_in,
   output logic [17:0] y,
   output logic        y_valid,
   output logic [1:0]  sym,
   output logic        overrun
);

   localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam logic [CW-1:0] PH_LAST = CW'(DECIM - 1);
   localparam logic [CW-1:0] PH_TRIG = CW'(PHASE);
   localparam logic signed [17:0] TH_POS = 18'(THRESH);
   localparam logic signed [17:0] TH_NEG = 18'(-THRESH);

   typedef enum logic [1:0] {IDLE, LOAD, MAC, OUT} state_t;

   state_t             state_q, state_d;
   logic [17:0]        x_q [0:20];
   logic [17:0]        x_d [0:20];
   logic signed [18:0] p_q [0:10];
   logic signed [18:0] p_d [0:10];
   logic [CW-1:0]      ph_q, ph_d;
   logic signed [40:0] acc_q, acc_d;
   logic [3:0]         k_q, k_d;
   logic [17:0]        y_q, y_d;
   logic               y_valid_q, y_valid_d;
   logic [1:0]         sym_q, sym_d;
   logic               ovr_q, ovr_d;

   logic               trig;
   logic signed [17:0] coef;
   logic signed [18:0] p_sel;
   logic signed [36:0] prod;
   logic signed [40:0] acc_rnd;
   logic signed [23:0] r_full;
   logic signed [17:0] r_red;
   logic [1:0]         sym_new;
   logic               unused_bits;

   // Delay line and phase counter run on every sample regardless of FSM state.
   always_comb begin
      for (int i = 0; i < 21; i++) x_d[i] = x_q[i];
      ph_d = ph_q;
      trig = 1'b0;
      if (sam_en) begin
         x_d[0] = x_in;
         for (int i = 1; i < 21; i++) x_d[i] = x_q[i-1];
         ph_d = (ph_q == PH_LAST) ? '0 : ph_q + 1'b1;
         trig = (ph_q == PH_TRIG);
      end
   end

   // Half-length coefficient table; tap k and tap 20-k share b[k].
   always_comb begin
      coef = '0;
      case (k_q)
         4'd0:    coef = 18'sd4095;
         4'd1:    coef = 18'sd5901;
         4'd2:    coef = 18'sd3327;
         4'd3:    coef = -18'sd3449;
         4'd4:    coef = -18'sd10679;
         4'd5:    coef = -18'sd12461;
         4'd6:    coef = -18'sd4028;
         4'd7:    coef = 18'sd14916;
         4'd8:    coef = 18'sd38992;
         4'd9:    coef = 18'sd59145;
         4'd10:   coef = 18'sd66992;
         default: coef = '0;
      endcase
   end

   always_comb begin
      p_sel = (k_q <= 4'd10) ? p_q[k_q] : '0;
      prod  = p_sel * coef;
   end

   always_comb begin
      acc_rnd = acc_q + 41'sd65536;
      r_full  = acc_rnd[40:17];
`ifdef RX_MF_SAT_EN
      if (r_full > 24'sd131071)
         r_red = 18'sh1FFFF;
      else if (r_full < -24'sd131072)
         r_red = 18'sh20000;
      else
         r_red = r_full[17:0];
`else
      r_red = r_full[17:0];
`endif
      unused_bits = ^{acc_rnd[16:0], r_full};
   end

   // Gray-coded 4-ASK: outer positive 10, inner positive 11, inner negative 01, outer negative 00.
   always_comb begin
      if (r_red >= TH_POS)
         sym_new = 2'b10;
      else if (r_red >= 18'sd0)
         sym_new = 2'b11;
      else if (r_red >= TH_NEG)
         sym_new = 2'b01;
      else
         sym_new = 2'b00;
   end

   always_comb begin
      state_d   = state_q;
      p_d       = p_q;
      acc_d     = acc_q;
      k_d       = k_q;
      y_d       = y_q;
      sym_d     = sym_q;
      y_valid_d = 1'b0;
      ovr_d     = ovr_q | (trig && (state_q != IDLE));
      case (state_q)
         IDLE: begin
            if (trig) state_d = LOAD;
         end
         LOAD: begin
            for (int i = 0; i < 10; i++)
               p_d[i] = {x_q[i][17], x_q[i]} + {x_q[20-i][17], x_q[20-i]};
            p_d[10] = {x_q[10][17], x_q[10]};
            acc_d   = '0;
            k_d     = '0;
            state_d = MAC;
         end
         MAC: begin
            acc_d = acc_q + {{4{prod[36]}}, prod};
            k_d   = k_q + 4'd1;
            if (k_q == 4'd10) state_d = OUT;
         end
         OUT: begin
            y_d       = r_red;
            sym_d     = sym_new;
            y_valid_d = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 21; i++) x_q[i] <= '0;
         for (int i = 0; i < 11; i++) p_q[i] <= '0;
         state_q   <= IDLE;
         ph_q      <= '0;
         acc_q     <= '0;
         k_q       <= '0;
         y_q       <= '0;
         y_valid_q <= 1'b0;
         sym_q     <= 2'b11;
         ovr_q     <= 1'b0;
      end else begin
         x_q       <= x_d;
         p_q       <= p_d;
         state_q   <= state_d;
         ph_q      <= ph_d;
         acc_q     <= acc_d;
         k_q       <= k_d;
         y_q       <= y_d;
         y_valid_q <= y_valid_d;
         sym_q     <= sym_d;
         ovr_q     <= ovr_d;
      end
   end

   assign y       = y_q;
   assign y_valid = y_valid_q;
   assign sym     = sym_q;
   assign overrun = ovr_q;

endmodule

// File: tb/tb_rx_mf_decim.sv
// Randomized and directed bench for rx_mf_decim against a sample-history reference model.
module tb_rx_mf_decim;

   localparam int DECIM  = 4;
   localparam int PHASE  = 0;
   localparam int THRESH = 43691;

   logic        clk;
   logic        reset;
   logic        sam_en;
   logic [17:0] x_in;
   logic [17:0] y;
   logic        y_valid;
   logic [1:0]  sym;
   logic        overrun;

   rx_mf_decim #(.DECIM(DECIM), .PHASE(PHASE), .THRESH(THRESH)) dut (
      .clk     (clk),
      .reset   (reset),
      .sam_en  (sam_en),
      .x_in    (x_in),
      .y       (y),
      .y_valid (y_valid),
      .sym     (sym),
      .overrun (overrun)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
   endtask

   // Reference model: filter taps h[j] = b[min(j, 20-j)] over the newest 21 accepted samples.
   int B [0:10] = '{4095, 5901, 3327, -3449, -10679, -12461, -4028, 14916, 38992, 59145, 66992};
   int hist [$];
   int cnt = 0;
   int cyc = 0;
   int t0 = 0;
   bit active = 0;
   bit ovr_m = 0;
   bit vld_m = 0;
   int y_m = 0;
   int sym_m = 3;
   int pend_y = 0;
   int obs_y [$];
   int obs_sym [$];

   function automatic int mf_ref();
      longint acc = 0;
      longint r;
      for (int j = 0; j < hist.size(); j++)
         acc += longint'(B[(j <= 10) ? j : 20 - j]) * longint'(hist[j]);
      r = (acc + 65536) >>> 17;
`ifdef RX_MF_SAT_EN
      if (r > 131071) r = 131071;
      if (r < -131072) r = -131072;
`else
      r = r & 64'h3FFFF;
      if (r >= 131072) r = r - 262144;
`endif
      return int'(r);
   endfunction

   function automatic int slice(input int v);
      if (v >= THRESH) return 2;
      else if (v >= 0) return 3;
      else if (v >= -THRESH) return 1;
      else return 0;
   endfunction

   task automatic model_edge(input bit se, input int xs, input bit rs);
      vld_m = 0;
      if (rs) begin
         hist.delete();
         cnt = 0; active = 0; ovr_m = 0; y_m = 0; sym_m = 3;
      end else begin
         if (se) begin
            bit trig;
            trig = ((cnt % DECIM) == PHASE);
            hist.push_front(xs);
            if (hist.size() > 21) void'(hist.pop_back());
            cnt++;
            if (trig) begin
               if (active && cyc <= t0 + 13) ovr_m = 1;
               else begin
                  active = 1;
                  t0 = cyc;
                  pend_y = mf_ref();
               end
            end
         end
         if (active && cyc == t0 + 13) begin
            vld_m = 1;
            y_m = pend_y;
            sym_m = slice(pend_y);
            active = 0;
         end
      end
      cyc++;
   endtask

   // Called at a falling edge: drive, let one rising edge pass, then compare at the next falling edge.
   task automatic step(input bit se, input logic [17:0] xv, input bit rs);
      reset  = rs;
      sam_en = se;
      x_in   = xv;
      @(posedge clk);
      model_edge(se, int'($signed(xv)), rs);
      @(negedge clk);
      chk("y_valid", int'(y_valid), int'(vld_m));
      chk("y", int'($signed(y)), y_m);
      chk("sym", int'(sym), sym_m);
      chk("overrun", int'(overrun), int'(ovr_m));
      if (y_valid) begin
         obs_y.push_back(int'($signed(y)));
         obs_sym.push_back(int'(sym));
      end
   endtask

   int imp_y   [0:6] = '{4095, -10679, 38992, 38992, -10679, 4095, 0};
   int imp_sym [0:6] = '{3, 1, 3, 3, 1, 3, 3};
   int nstrobe;
   int dens;
   logic [17:0] xr;

   initial begin
      reset = 1'b1; sam_en = 1'b0; x_in = '0;
      @(negedge clk);
      step(0, '0, 1);
      step(0, '0, 1);

      // Quiet period after reset.
      for (int i = 0; i < 50; i++) step(0, '0, 0);

      // Impulse response, one sample every 16 clocks.
      step(0, '0, 1);
      obs_y.delete(); obs_sym.delete();
      for (int i = 0; i < 30 * 16; i++)
         step(i % 16 == 0, (i == 0) ? 18'd131071 : 18'd0, 0);
      for (int j = 0; j < 7; j++) begin
         chk($sformatf("imp_y%0d", j), (j < obs_y.size()) ? obs_y[j] : 999999, imp_y[j]);
         chk($sformatf("imp_sym%0d", j), (j < obs_sym.size()) ? obs_sym[j] : 99, imp_sym[j]);
      end

      // DC full-scale input.
      step(0, '0, 1);
      obs_y.delete(); obs_sym.delete();
      for (int i = 0; i < 40 * 16; i++) step(i % 16 == 0, 18'd131071, 0);
`ifdef RX_MF_SAT_EN
      chk("dc_y", (obs_y.size() > 0) ? obs_y[$] : 999999, 131071);
      chk("dc_sym", (obs_sym.size() > 0) ? obs_sym[$] : 99, 2);
`else
      chk("dc_y", (obs_y.size() > 0) ? obs_y[$] : 999999, -3636);
      chk("dc_sym", (obs_sym.size() > 0) ? obs_sym[$] : 99, 1);
`endif

      // Overrun: trigger every 8 clocks, only every other one can be served.
      step(0, '0, 1);
      obs_y.delete(); obs_sym.delete();
      for (int i = 0; i < 200; i++) step(i % 2 == 0, 18'($urandom), 0);
      chk("ovr_set", int'(overrun), 1);
      chk("ovr_strobes", obs_y.size(), 12);
      for (int i = 0; i < 60; i++) step(0, '0, 0);
      chk("ovr_sticky", int'(overrun), 1);

      // Reset in the middle of the MAC phase.
      step(0, '0, 1);
      obs_y.delete(); obs_sym.delete();
      step(1, 18'd131071, 0);
      for (int i = 0; i < 4; i++) step(0, '0, 0);
      step(0, '0, 1);
      for (int i = 0; i < 20; i++) step(0, '0, 0);
      chk("mid_nostrobe", obs_y.size(), 0);
      for (int i = 0; i < 40; i++) step(i % 4 == 0, '0, 0);
      chk("mid_y0", (obs_y.size() > 0) ? obs_y[0] : 999999, 0);

      // Randomized traffic with varying sample density and occasional resets.
      step(0, '0, 1);
      for (int blk = 0; blk < 8; blk++) begin
         dens = $urandom_range(1, 16);
         for (int i = 0; i < 500; i++) begin
            case ($urandom % 4)
               0:       xr = 18'h1FFFF;
               1:       xr = 18'h20000;
               default: xr = 18'($urandom);
            endcase
            step($urandom_range(0, dens - 1) == 0, xr, ($urandom % 700) == 0);
         end
      end

      nstrobe = 0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
